hamming32t26d_scrub: RTL and testbench

HAMMING32T26D_SCRUB -- requirements
Module: hamming32t26d_scrub

---
 rtl/hamming32t26d_scrub.sv | 196 +++++++++++++++++++
 tb/tb_hamming32t26d_scrub.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming32t26d_scrub.sv
// SEC-DED (32,26) protected register-file memory with a background scrubber.
// Define HAMMING_SCRUB_INJECT_EN to add the inj_* error-injection ports.
module hamming32t26d_scrub #(
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [25:0]                wr_data_i,
    input  logic                       rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [25:0]                rd_data_o,
    output logic                       rd_valid_o,
    output logic                       rd_ded_o,
    input  logic                       scrub_en_i,
    output logic [$clog2(DEPTH)-1:0]   scrub_addr_o,
    output logic [CNT_WIDTH-1:0]       sec_cnt_o,
    output logic [CNT_WIDTH-1:0]       ded_cnt_o,
    output logic                       ded_irq_o,
    input  logic                       irq_clr_i
`ifdef HAMMING_SCRUB_INJECT_EN
   ,input  logic                       inj_en_i,
    input  logic [$clog2(DEPTH)-1:0]   inj_addr_i,
    input  logic [31:0]                inj_mask_i
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CHECK, FIX} state_e;

    // Data bits fill every non-power-of-two position above 0, in ascending order.
    function automatic logic [31:0] encode(input logic [25:0] d);
        logic [31:0] cw;
        int          k;
        cw = '0;
        k  = 0;
        for (int i = 3; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[k];
                k++;
            end
        end
        for (int p = 0; p < 5; p++) begin
            for (int i = 3; i < 32; i++) begin
                if ((i & (1 << p)) != 0) cw[1 << p] ^= cw[i];
            end
        end
        cw[0] = ^cw[31:1];
        return cw;
    endfunction

    // Returns {overall parity error, 5-bit syndrome}.
    function automatic logic [5:0] check_bits(input logic [31:0] cw);
        logic [4:0] s;
        s = '0;
        for (int i = 1; i < 32; i++) begin
            if (cw[i]) s ^= 5'(i);
        end
        return {^cw, s};
    endfunction

    function automatic logic [25:0] correct(input logic [31:0] cw);
        logic [5:0]  cb;
        logic [31:0] fixed;
        logic [25:0] d;
        int          k;
        cb    = check_bits(cw);
        fixed = cw;
        if (cb[5]) fixed[cb[4:0]] = ~fixed[cb[4:0]];
        d = '0;
        k = 0;
        for (int i = 3; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[k] = fixed[i];
                k++;
            end
        end
        return d;
    endfunction

    logic [31:0]          mem_q [DEPTH];
    state_e               state_q, state_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_WIDTH-1:0] ded_cnt_q, ded_cnt_d;
    logic                 irq_q, irq_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [25:0]          rd_data_q, rd_data_d;
    logic                 rd_ded_q, rd_ded_d;

    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [31:0]          mem_wdata;
    logic [5:0]           rd_cb, scr_cb;
    logic                 irq_set;
`ifdef HAMMING_SCRUB_INJECT_EN
    logic [31:0]          inj_base;
`endif

    // NOTE: every variable assigned here gets a default first, so no latches are inferred.
    always_comb begin
        rd_cb      = check_bits(mem_q[rd_addr_i]);
        scr_cb     = check_bits(mem_q[ptr_q]);
        state_d    = state_q;
        ptr_d      = ptr_q;
        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;
        mem_we     = wr_en_i;
        mem_waddr  = wr_addr_i;
        mem_wdata  = encode(wr_data_i);
        rd_valid_d = rd_en_i;
        rd_data_d  = rd_en_i ? correct(mem_q[rd_addr_i]) : rd_data_q;
        rd_ded_d   = rd_en_i ? (!rd_cb[5] && rd_cb[4:0] != '0) : rd_ded_q;
        irq_set    = rd_en_i && !rd_cb[5] && rd_cb[4:0] != '0;

        case (state_q)
            IDLE: begin
                if (scrub_en_i) state_d = CHECK;
            end
            CHECK: begin
                if (!scrub_en_i) begin
                    state_d = IDLE;
                end else if (scr_cb[5]) begin
                    state_d = FIX;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                    if (scr_cb[4:0] != '0) begin
                        irq_set = 1'b1;
                        if (ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            FIX: begin
                // A user write to another address owns the single write port; retry next cycle.
                if (!(wr_en_i && wr_addr_i != ptr_q)) begin
                    if (!wr_en_i) begin
                        mem_we    = 1'b1;
                        mem_waddr = ptr_q;
                        mem_wdata = encode(correct(mem_q[ptr_q]));
                    end
                    if (sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + CNT_WIDTH'(1);
                    ptr_d   = ptr_q + AW'(1);
                    state_d = scrub_en_i ? CHECK : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        irq_d = irq_set ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);

`ifdef HAMMING_SCRUB_INJECT_EN
        inj_base = (mem_we && mem_waddr == inj_addr_i) ? mem_wdata : mem_q[inj_addr_i];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ded_q   <= 1'b0;
            // NOTE: the memory is reset on purpose; all-zero is the valid codeword of data 0.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
            irq_q      <= irq_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ded_q   <= rd_ded_d;
            if (mem_we) mem_q[mem_waddr] <= mem_wdata;
`ifdef HAMMING_SCRUB_INJECT_EN
            if (inj_en_i) mem_q[inj_addr_i] <= inj_base ^ inj_mask_i;
`endif
        end
    end

    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign rd_ded_o     = rd_ded_q;
    assign scrub_addr_o = ptr_q;
    assign sec_cnt_o    = sec_cnt_q;
    assign ded_cnt_o    = ded_cnt_q;
    assign ded_irq_o    = irq_q;

endmodule

// File: tb/tb_hamming32t26d_scrub.sv
// Scoreboard bench for hamming32t26d_scrub; the model tracks plain data plus an
// injected-error mask per word. Error scenarios run when HAMMING_SCRUB_INJECT_EN is defined.
module tb_hamming32t26d_scrub;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          wr_en_i = 1'b0, rd_en_i = 1'b0, scrub_en_i = 1'b0, irq_clr_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0, rd_addr_i = '0;
    logic [25:0]   wr_data_i = '0;
    logic [25:0]   rd_data_o;
    logic          rd_valid_o, rd_ded_o, ded_irq_o;
    logic [AW-1:0] scrub_addr_o;
    logic [CW-1:0] sec_cnt_o, ded_cnt_o;
`ifdef HAMMING_SCRUB_INJECT_EN
    logic          inj_en_i = 1'b0;
    logic [AW-1:0] inj_addr_i = '0;
    logic [31:0]   inj_mask_i = '0;
`endif

    always #5 clk = ~clk;

    hamming32t26d_scrub #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .rd_ded_o(rd_ded_o),
        .scrub_en_i(scrub_en_i), .scrub_addr_o(scrub_addr_o),
        .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o),
        .ded_irq_o(ded_irq_o), .irq_clr_i(irq_clr_i)
`ifdef HAMMING_SCRUB_INJECT_EN
       ,.inj_en_i(inj_en_i), .inj_addr_i(inj_addr_i), .inj_mask_i(inj_mask_i)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [25:0] data;
        logic        ded;
    } exp_t;

    exp_t        sb[$];
    logic [25:0] m_data [DEPTH];
    logic [31:0] m_mask [DEPTH];
    logic [25:0] last_data;
    logic        last_ded;
    bit          last_known;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per rd_valid_o; otherwise read outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i) begin
            if (rd_valid_o) begin
                if (sb.size() == 0) begin
                    check("rd_valid_unexpected", {31'd0, rd_valid_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_latency", cyc, e.cyc);
                    check("rd_ded", {31'd0, rd_ded_o}, {31'd0, e.ded});
                    if (!e.ded) check("rd_data", {6'd0, rd_data_o}, {6'd0, e.data});
                    last_data  = e.data;
                    last_ded   = e.ded;
                    last_known = !e.ded;
                end
            end else begin
                check("rd_ded_hold", {31'd0, rd_ded_o}, {31'd0, last_ded});
                if (last_known) check("rd_data_hold", {6'd0, rd_data_o}, {6'd0, last_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [AW-1:0] a);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = m_data[a];
        e.ded  = ($countones(m_mask[a]) == 2);
        sb.push_back(e);
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] wa, input logic [25:0] wd,
                         input bit r, input logic [AW-1:0] ra);
        wr_en_i = w; wr_addr_i = wa; wr_data_i = wd;
        rd_en_i = r; rd_addr_i = ra;
        if (r) push_read(ra);
        if (w) begin
            m_data[wa] = wd;
            m_mask[wa] = '0;
        end
        tick();
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
    endtask

    task automatic do_reset();
        scrub_en_i = 1'b0;
        irq_clr_i  = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_mask[i] = '0;
        end
        last_data  = '0;
        last_ded   = 1'b0;
        last_known = 1'b1;
        rst_i = 1'b0;
    endtask

    task automatic wait_ptr(input logic [AW-1:0] target, input int budget);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            tick();
            if (scrub_addr_o == target) hit = 1'b1;
        end
        check("wait_ptr_timeout", {31'd0, hit}, 32'd1);
    endtask

`ifdef HAMMING_SCRUB_INJECT_EN
    task automatic inject(input logic [AW-1:0] a, input logic [31:0] mask);
        inj_en_i = 1'b1; inj_addr_i = a; inj_mask_i = mask;
        m_mask[a] ^= mask;
        tick();
        inj_en_i = 1'b0;
    endtask

    // A full scrubber pass repairs every single-bit error.
    task automatic model_scrub_pass();
        for (int i = 0; i < DEPTH; i++) begin
            if ($countones(m_mask[i]) == 1) m_mask[i] = '0;
        end
    endtask

    function automatic logic [31:0] rand_mask(input int nbits);
        logic [31:0] m;
        int          b;
        m = '0;
        while ($countones(m) < nbits) begin
            b = $urandom_range(0, 31);
            m[b] = 1'b1;
        end
        return m;
    endfunction
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          w, r;
        logic [AW-1:0] wa, ra;
        logic [25:0]   wd;

        do_reset();
        check("reset_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        check("reset_rd_data", {6'd0, rd_data_o}, 32'd0);
        check("reset_rd_ded", {31'd0, rd_ded_o}, 32'd0);
        check("reset_scrub_addr", {28'd0, scrub_addr_o}, 32'd0);
        check("reset_sec_cnt", {30'd0, sec_cnt_o}, 32'd0);
        check("reset_ded_cnt", {30'd0, ded_cnt_o}, 32'd0);
        check("reset_irq", {31'd0, ded_irq_o}, 32'd0);

        // Reset content reads back as clean zero; then the basic write/read case.
        issue(0, 0, 0, 1, 4'd9);
        issue(1, 4'd3, 26'h2AAAAAA, 0, 0);
        issue(0, 0, 0, 1, 4'd3);
        // Same-address read and write return the old content.
        issue(1, 4'd3, 26'h1234567, 1, 4'd3);
        issue(0, 0, 0, 1, 4'd3);
        issue(1, 4'd15, 26'h3FFFFFF, 0, 0);
        issue(0, 0, 0, 1, 4'd15);

        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = AW'($urandom_range(0, DEPTH - 1));
            wd = 26'($urandom);
            if ($urandom_range(0, 3) == 0) ra = wa;
            wr_en_i = w; wr_addr_i = wa; wr_data_i = wd;
            rd_en_i = r; rd_addr_i = ra;
            if (r) push_read(ra);
            if (w) begin
                m_data[wa] = wd;
                m_mask[wa] = '0;
            end
`ifdef HAMMING_SCRUB_INJECT_EN
            inj_en_i   = 1'b0;
            inj_addr_i = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 5) == 0 && m_mask[inj_addr_i] == '0) begin
                inj_en_i   = 1'b1;
                inj_mask_i = rand_mask($urandom_range(1, 2));
                m_mask[inj_addr_i] = inj_mask_i;
            end
`endif
            tick();
        end
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
`ifdef HAMMING_SCRUB_INJECT_EN
        inj_en_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) issue(0, 0, 0, 1, AW'(i));
        tick();
        tick();
        check("sb_drain_random", sb.size(), 0);
        do_reset();
`else
        tick();
        tick();
        check("sb_drain_random", sb.size(), 0);
        check("irq_clean_traffic", {31'd0, ded_irq_o}, 32'd0);
`endif

        // Clean scrub pass of all 16 words returns the pointer to 0.
        scrub_en_i = 1'b1;
        tick();
        check("scrub_enter_ptr", {28'd0, scrub_addr_o}, 32'd0);
        repeat (8) tick();
        check("scrub_mid_ptr", {28'd0, scrub_addr_o}, 32'd8);
        repeat (8) tick();
        check("scrub_wrap_ptr", {28'd0, scrub_addr_o}, 32'd0);
        check("scrub_clean_sec", {30'd0, sec_cnt_o}, 32'd0);
        check("scrub_clean_ded", {30'd0, ded_cnt_o}, 32'd0);
        scrub_en_i = 1'b0;
        repeat (3) tick();
        check("scrub_stop_ptr", {28'd0, scrub_addr_o}, 32'd0);
        for (int i = 0; i < DEPTH; i += 5) issue(0, 0, 0, 1, AW'(i));

`ifdef HAMMING_SCRUB_INJECT_EN
        // Single flip in a check-bit position is corrected on read.
        do_reset();
        issue(1, 4'd5, 26'h155, 0, 0);
        inject(4'd5, 32'h0001_0000);
        issue(0, 0, 0, 1, 4'd5);
        tick();
        check("sec_read_irq", {31'd0, ded_irq_o}, 32'd0);

        // Double flip found by the scrubber.
        inject(4'd7, 32'h0000_0006);
        scrub_en_i = 1'b1;
        wait_ptr(4'd7, 40);
        tick();
        check("ded_scrub_ptr", {28'd0, scrub_addr_o}, 32'd8);
        check("ded_scrub_cnt", {30'd0, ded_cnt_o}, 32'd1);
        check("ded_scrub_irq", {31'd0, ded_irq_o}, 32'd1);
        check("ded_scrub_sec", {30'd0, sec_cnt_o}, 32'd1);
        scrub_en_i = 1'b0;
        irq_clr_i  = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        check("irq_clear", {31'd0, ded_irq_o}, 32'd0);

        // Full pass repairs a single flip exactly once.
        do_reset();
        issue(1, 4'd2, 26'h0ABCDEF, 0, 0);
        inject(4'd2, 32'h0010_0000);
        scrub_en_i = 1'b1;
        repeat (20) tick();
        check("pass_sec_cnt", {30'd0, sec_cnt_o}, 32'd1);
        check("pass_ded_cnt", {30'd0, ded_cnt_o}, 32'd0);
        repeat (20) tick();
        check("pass2_sec_cnt", {30'd0, sec_cnt_o}, 32'd1);
        scrub_en_i = 1'b0;
        tick();
        model_scrub_pass();
        issue(0, 0, 0, 1, 4'd2);

        // User write to the FIX address cancels the writeback.
        do_reset();
        issue(1, 4'd4, 26'h1111111, 0, 0);
        inject(4'd4, 32'h0000_0200);
        scrub_en_i = 1'b1;
        repeat (6) tick();
        issue(1, 4'd4, 26'h2222222, 0, 0);
        check("fix_cancel_ptr", {28'd0, scrub_addr_o}, 32'd5);
        check("fix_cancel_sec", {30'd0, sec_cnt_o}, 32'd1);
        scrub_en_i = 1'b0;
        tick();
        issue(0, 0, 0, 1, 4'd4);

        // User write elsewhere stalls FIX for one cycle.
        do_reset();
        issue(1, 4'd4, 26'h0333333, 0, 0);
        inject(4'd4, 32'h4000_0000);
        scrub_en_i = 1'b1;
        repeat (6) tick();
        issue(1, 4'd9, 26'h0444444, 0, 0);
        check("fix_stall_ptr", {28'd0, scrub_addr_o}, 32'd4);
        check("fix_stall_sec", {30'd0, sec_cnt_o}, 32'd0);
        tick();
        check("fix_done_ptr", {28'd0, scrub_addr_o}, 32'd5);
        check("fix_done_sec", {30'd0, sec_cnt_o}, 32'd1);
        scrub_en_i = 1'b0;
        tick();
        m_mask[4] = '0;
        issue(0, 0, 0, 1, 4'd4);
        issue(0, 0, 0, 1, 4'd9);

        // Five double errors saturate a 2-bit counter at 3.
        do_reset();
        for (int i = 0; i < 15; i += 3) inject(AW'(i), 32'h0000_0300);
        scrub_en_i = 1'b1;
        repeat (18) tick();
        check("ded_saturate", {30'd0, ded_cnt_o}, 32'd3);
        check("ded_sat_sec", {30'd0, sec_cnt_o}, 32'd0);
        scrub_en_i = 1'b0;
        irq_clr_i  = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        check("irq_clear2", {31'd0, ded_irq_o}, 32'd0);

        // A user DED read sets the flag, and set beats a simultaneous clear.
        issue(0, 0, 0, 1, 4'd3);
        check("irq_user_read", {31'd0, ded_irq_o}, 32'd1);
        irq_clr_i = 1'b1;
        issue(0, 0, 0, 1, 4'd6);
        check("irq_set_wins", {31'd0, ded_irq_o}, 32'd1);
        tick();
        irq_clr_i = 1'b0;
        check("irq_clear3", {31'd0, ded_irq_o}, 32'd0);
`endif

        tick();
        tick();
        check("sb_drain_final", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
